// File: rtl/disp_wr_arbiter.sv
// Round-robin arbiter + frame-clear engine sharing the 512x8 display RAM write port.
// Latency: an accepted beat (gnt_o[k] & req_i[k]) appears on wr_* one cycle later; grants one edge after arbitration.
// Backpressure: requesters stall on gnt_o; hold_in blocks new grants/clears but never interrupts an active one.
//
// Ports:
//   clk_in, rst_n_in           clock, synchronous active-low reset
//   req_i/addr_i/data_i/last_i per-requester write beat (requester k at 9k / 8k bit offsets)
//   gnt_o                      one-hot registered grant
//   clr_req, hold_in           clear request pulse, arbitration gate
//   wr_addr/wr_data/wr_en      registered RAM write port
//   clr_busy, clr_done         clear in progress, one-cycle completion pulse
module disp_wr_arbiter #(
    parameter int NREQ      = 3,
    parameter int MAX_BURST = 64
) (
    input  logic                 clk_in,
    input  logic                 rst_n_in,
    input  logic [NREQ-1:0]      req_i,
    input  logic [9*NREQ-1:0]    addr_i,
    input  logic [8*NREQ-1:0]    data_i,
    input  logic [NREQ-1:0]      last_i,
    output logic [NREQ-1:0]      gnt_o,
    input  logic                 clr_req,
    input  logic                 hold_in,
    output logic [8:0]           wr_addr,
    output logic [7:0]           wr_data,
    output logic                 wr_en,
    output logic                 clr_busy,
    output logic                 clr_done
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, GRANT, CLEAR} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [BW-1:0]   beat_q, beat_d;
    logic [8:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [8:0]      wr_addr_q, wr_addr_d;
    logic [7:0]      wr_data_q, wr_data_d;
    logic            wr_en_q, wr_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [8:0] addr_arr [NREQ];
    logic [7:0] data_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign addr_arr[g] = addr_i[9*g+8 : 9*g];
        assign data_arr[g] = data_i[8*g+7 : 8*g];
    end

    // Rotating search: first requester at or after ptr_q, wrapping.
    logic [IW-1:0] sel;
    logic          found;
    logic [IW:0]   j;

    always_comb begin
        sel   = ptr_q;
        found = 1'b0;
        j     = '0;
        for (int i = 0; i < NREQ; i++) begin
            j = {1'b0, ptr_q} + (IW+1)'(i);
            if (j >= (IW+1)'(NREQ)) begin
                j = j - (IW+1)'(NREQ);
            end
            if (!found && req_i[j[IW-1:0]]) begin
                found = 1'b1;
                sel   = j[IW-1:0];
            end
        end
    end

    logic cur_req;
    logic grant_end;

    assign cur_req   = req_i[idx_q];
    // A dropped request ends the grant without a write.
    assign grant_end = !cur_req || last_i[idx_q] || (beat_q == BW'(MAX_BURST - 1));

    // State register (all registers reset synchronously).
    always_ff @(posedge clk_in) begin
        if (!rst_n_in) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            ptr_q     <= '0;
            beat_q    <= '0;
            cnt_q     <= '0;
            pend_q    <= 1'b0;
            gnt_q     <= '0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            ptr_q     <= ptr_d;
            beat_q    <= beat_d;
            cnt_q     <= cnt_d;
            pend_q    <= pend_d;
            gnt_q     <= gnt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (!hold_in) begin
                    if (pend_q) begin
                        state_d = CLEAR;
                    end else if (found) begin
                        state_d = GRANT;
                    end
                end
            end
            GRANT: begin
                if (grant_end) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (cnt_q == 9'h1FF) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath next values.
    always_comb begin
        idx_d     = idx_q;
        ptr_d     = ptr_q;
        beat_d    = beat_q;
        cnt_d     = cnt_q;
        pend_d    = pend_q | clr_req;
        gnt_d     = gnt_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
        busy_d    = 1'b0;
        // The final clear write is the only busy write to address 511.
        done_d    = busy_q && (wr_addr_q == 9'h1FF);

        case (state_q)
            IDLE: begin
                if (state_d == GRANT) begin
                    idx_d      = sel;
                    beat_d     = '0;
                    gnt_d      = '0;
                    gnt_d[sel] = 1'b1;
                end else if (state_d == CLEAR) begin
                    cnt_d = '0;
                end
            end
            GRANT: begin
                if (cur_req) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_arr[idx_q];
                    wr_data_d = data_arr[idx_q];
                    beat_d    = beat_q + BW'(1);
                end
                if (grant_end) begin
                    gnt_d = '0;
                    ptr_d = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + IW'(1);
                end
            end
            CLEAR: begin
                // Flag stays set while clearing so repeat requests are absorbed.
                pend_d    = (cnt_q == 9'h1FF) ? 1'b0 : pend_q;
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q;
                wr_data_d = 8'h00;
                busy_d    = 1'b1;
                cnt_d     = cnt_q + 9'd1;
            end
            default: ;
        endcase
    end

    assign gnt_o    = gnt_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign wr_en    = wr_en_q;
    assign clr_busy = busy_q;
    assign clr_done = done_q;

endmodule

// File: tb/tb_disp_wr_arbiter.sv
// Testbench for disp_wr_arbiter: directed scenarios then randomized traffic.
// Latency: outputs compared every cycle, 1 time unit after the rising edge.
// Backpressure: a behavioural model predicts grants, writes and clear activity.
module tb_disp_wr_arbiter;

    localparam int NREQ = 3;
    localparam int MAXB = 64;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  req, last, gnt;
    logic [26:0] addr;
    logic [23:0] data;
    logic        clr, hold;
    logic [8:0]  wa;
    logic [7:0]  wd;
    logic        we, busy, done;

    always #5 clk = ~clk;

    disp_wr_arbiter #(.NREQ(NREQ), .MAX_BURST(MAXB)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .req_i    (req),
        .addr_i   (addr),
        .data_i   (data),
        .last_i   (last),
        .gnt_o    (gnt),
        .clr_req  (clr),
        .hold_in  (hold),
        .wr_addr  (wa),
        .wr_data  (wd),
        .wr_en    (we),
        .clr_busy (busy),
        .clr_done (done)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Behavioural model: mode 0 idle, 1 granted, 2 clearing.
    int         m_mode = 0, m_k = 0, m_ptr = 0, m_beats = 0, m_cnt = 0;
    bit         m_pend = 0, m_done_nx = 0;
    logic [2:0] e_gnt = 0;
    logic       e_wen = 0, e_busy = 0, e_done = 0;
    logic [8:0] e_addr = 0;
    logic [7:0] e_data = 0;

    function automatic bit bit_of(input logic [2:0] v, input int idx);
        return ((v >> idx) & 3'b001) != 3'b000;
    endfunction

    task automatic model_edge();
        bit fin;
        if (!rst_n) begin
            m_mode = 0; m_k = 0; m_ptr = 0; m_beats = 0; m_cnt = 0;
            m_pend = 0; m_done_nx = 0;
            e_gnt = 0; e_wen = 0; e_busy = 0; e_done = 0; e_addr = 0; e_data = 0;
        end else begin
            e_done    = m_done_nx;
            m_done_nx = 0;
            e_wen     = 0;
            e_busy    = 0;
            fin       = 0;
            case (m_mode)
                0: begin
                    if (!hold) begin
                        if (m_pend) begin
                            m_mode = 2;
                            m_cnt  = 0;
                        end else if (req != 3'b000) begin
                            for (int i = 0; i < NREQ; i++) begin
                                if (bit_of(req, (m_ptr + i) % NREQ)) begin
                                    m_k = (m_ptr + i) % NREQ;
                                    break;
                                end
                            end
                            m_mode  = 1;
                            m_beats = 0;
                            e_gnt   = 3'(1 << m_k);
                        end
                    end
                    if (clr) m_pend = 1;
                end
                1: begin
                    if (clr) m_pend = 1;
                    if (bit_of(req, m_k)) begin
                        e_wen  = 1;
                        e_addr = 9'(addr >> (9 * m_k));
                        e_data = 8'(data >> (8 * m_k));
                        m_beats++;
                        if (bit_of(last, m_k) || m_beats == MAXB) fin = 1;
                    end else begin
                        fin = 1;
                    end
                    if (fin) begin
                        m_mode = 0;
                        e_gnt  = 0;
                        m_ptr  = (m_k + 1) % NREQ;
                    end
                end
                default: begin
                    e_wen  = 1;
                    e_busy = 1;
                    e_addr = 9'(m_cnt);
                    e_data = 8'h00;
                    if (m_cnt == 511) begin
                        m_mode    = 0;
                        m_pend    = 0;
                        m_done_nx = 1;
                    end else begin
                        m_cnt++;
                    end
                end
            endcase
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", 32'(gnt), 32'(e_gnt));
        chk("onehot", 32'($onehot0(gnt)), 32'd1);
        chk("wr_en", 32'(we), 32'(e_wen));
        if (e_wen) begin
            chk("wr_addr", 32'(wa), 32'(e_addr));
            chk("wr_data", 32'(wd), 32'(e_data));
        end
        chk("clr_busy", 32'(busy), 32'(e_busy));
        chk("clr_done", 32'(done), 32'(e_done));
    endtask

    bit [2:0] act;

    task automatic drive_random();
        for (int i = 0; i < NREQ; i++) begin
            if (act[i]) begin
                if ($urandom_range(9) == 0) act[i] = 1'b0;
            end else if ($urandom_range(3) == 0) begin
                act[i] = 1'b1;
            end
        end
        req   = act;
        last  = 3'($urandom_range(7)) & 3'($urandom_range(7));
        addr  = 27'($urandom);
        data  = 24'($urandom);
        clr   = ($urandom_range(199) == 0);
        hold  = ($urandom_range(7) == 0);
        rst_n = ($urandom_range(299) != 0);
    endtask

    int cnt_a, cnt_b;
    logic [2:0] exp_g;

    initial begin
        rst_n = 0; req = 0; last = 0; addr = 0; data = 0; clr = 0; hold = 0;
        step();
        step();
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wr_en", 32'(we), 32'd0);
        chk("rst_wr_addr", 32'(wa), 32'd0);
        chk("rst_wr_data", 32'(wd), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        rst_n = 1;

        // Two requesters from reset: index 0 first, one idle cycle, then index 2.
        req = 3'b101;
        step(); chk("r30_first", 32'(gnt), 32'd1);
        last = 3'b001;
        step(); chk("r30_gap", 32'(gnt), 32'd0);
        last = 3'b000;
        step(); chk("r30_second", 32'(gnt), 32'd4);
        req = 3'b000;
        step(); step();

        // Requester 1: three-beat burst.
        req = 3'b010;
        step(); chk("r31_gnt", 32'(gnt), 32'd2);
        for (int b = 0; b < 3; b++) begin
            addr = 27'(9'h10 + b) << 9;
            data = 24'(8'hA1 + b) << 8;
            last = (b == 2) ? 3'b010 : 3'b000;
            step();
            chk("r31_wen", 32'(we), 32'd1);
            chk("r31_addr", 32'(wa), 32'(9'h10 + b));
            chk("r31_data", 32'(wd), 32'(8'hA1 + b));
        end
        chk("r31_release", 32'(gnt), 32'd0);
        req = 3'b000; last = 3'b000;
        step();

        // Requester 0 streams without last: forced release after MAXB beats.
        req = 3'b011;
        step(); chk("r32_gnt0", 32'(gnt), 32'd1);
        cnt_a = 0;
        for (int b = 0; b < MAXB; b++) begin
            addr = 27'($urandom); data = 24'($urandom);
            step();
            if (we) cnt_a++;
        end
        chk("r32_beats", 32'(cnt_a), 32'(MAXB));
        chk("r32_release", 32'(gnt), 32'd0);
        step(); chk("r32_gnt1", 32'(gnt), 32'd2);
        req = 3'b000;
        step();

        // Clear requested mid-burst: burst finishes, full clear, then pending requester.
        req = 3'b100;
        step(); chk("r33_gnt2", 32'(gnt), 32'd4);
        step();
        clr = 1; step(); clr = 0;
        step();
        last = 3'b100; step(); chk("r33_end", 32'(gnt), 32'd0);
        last = 3'b000; req = 3'b001;
        cnt_a = 0; cnt_b = 0;
        for (int c = 0; c < 700; c++) begin
            step();
            if (we && busy) cnt_a++;
            if (done) cnt_b++;
            if (gnt == 3'b001) break;
        end
        chk("r33_clr_writes", 32'(cnt_a), 32'd512);
        chk("r33_done_pulses", 32'(cnt_b), 32'd1);
        chk("r33_after_gnt", 32'(gnt), 32'd1);
        req = 3'b000;
        step(); step();

        // hold_in blocks arbitration until released.
        hold = 1; req = 3'b111;
        for (int c = 0; c < 4; c++) begin
            step(); chk("r34_held", 32'(gnt), 32'd0);
        end
        exp_g = 3'(1 << m_ptr);
        hold = 0;
        step(); chk("r34_gnt", 32'(gnt), 32'(exp_g));
        req = 3'b000;
        step(); step();

        // Reset in the middle of a clear aborts it for good.
        clr = 1; step(); clr = 0;
        cnt_a = 0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (we && busy && wa == 9'd200) begin
                cnt_a = 1;
                break;
            end
        end
        chk("r35_reached", 32'(cnt_a), 32'd1);
        rst_n = 0;
        step();
        chk("r35_wen", 32'(we), 32'd0);
        chk("r35_busy", 32'(busy), 32'd0);
        rst_n = 1;
        cnt_b = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (we) cnt_b++;
        end
        chk("r35_no_resume", 32'(cnt_b), 32'd0);

        // Randomized traffic against the model.
        act = 3'b000;
        for (int c = 0; c < 6000; c++) begin
            drive_random();
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/disp_wr_arbiter.md
DISP_WR_ARBITER -- requirements
Module: disp_wr_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 3, giving the number of write requesters sharing the 512x8 display RAM write port.
REQ-002 The block SHALL have parameter MAX_BURST, default 64, giving the maximum accepted beats per grant before forced release.
REQ-003 The block SHALL have port clk_in  input  1  the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port rst_n_in  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port req_i  input  NREQ  per-requester write request.
REQ-006 The block SHALL have port addr_i  input  9*NREQ  per-requester RAM address, requester k in bits [9k+8:9k].
REQ-007 The block SHALL have port data_i  input  8*NREQ  per-requester write data, requester k in bits [8k+7:8k].
REQ-008 The block SHALL have port last_i  input  NREQ  per-requester end-of-burst flag, qualified by an accepted beat.
REQ-009 The block SHALL have port gnt_o  output  NREQ  one-hot grant, registered.
REQ-010 The block SHALL have port clr_req  input  1  single-cycle request to clear the whole frame buffer.
REQ-011 The block SHALL have port hold_in  input  1  blocks new grants and clear starts while high.
REQ-012 The block SHALL have port wr_addr  output  9  RAM write address, registered.
REQ-013 The block SHALL have port wr_data  output  8  RAM write data, registered.
REQ-014 The block SHALL have port wr_en  output  1  RAM write enable, registered.
REQ-015 The block SHALL have port clr_busy  output  1  high while the clear engine owns the port.
REQ-016 The block SHALL have port clr_done  output  1  one-cycle pulse after the final clear write.

Function
REQ-017 The block SHALL implement states IDLE, GRANT and CLEAR.
REQ-018 In IDLE with hold_in low, a pending clear SHALL take priority: the block enters CLEAR on the next edge.
REQ-019 Otherwise, in IDLE with hold_in low and any req_i bit high, the block SHALL select the first requesting index at or after the round-robin pointer (wrapping modulo NREQ), enter GRANT and assert that gnt_o bit on the next edge.
REQ-020 A beat SHALL be accepted in any cycle where gnt_o[k] and req_i[k] are both high; on the next edge wr_en=1, wr_addr=addr_i[k], wr_data=data_i[k] (latency 1 cycle); wr_en SHALL be 0 in all other cycles except CLEAR.
REQ-021 GRANT SHALL end, returning to IDLE with gnt_o=0 on the next edge, when an accepted beat has last_i[k]=1, when req_i[k] is low while granted (no write), or when the MAX_BURST-th beat is accepted.
REQ-022 On leaving GRANT the round-robin pointer SHALL become (k+1) mod NREQ; a requester that stays asserted re-arbitrates from IDLE, so IDLE lasts at least one cycle between grants.
REQ-023 hold_in SHALL NOT interrupt an active GRANT or CLEAR; it only gates departures from IDLE.
REQ-024 clr_req SHALL set a pending flag in any state; a clr_req while the flag is set or while in CLEAR SHALL be absorbed with no second clear.
REQ-025 In CLEAR a 9-bit counter from 0 to 511 SHALL produce one write per cycle, wr_addr=counter and wr_data=8'h00, with clr_busy=1 and gnt_o=0.
REQ-026 After the write to address 511 the block SHALL return to IDLE, pulse clr_done for exactly one cycle, clear the pending flag and leave the round-robin pointer unchanged.
REQ-027 gnt_o SHALL be one-hot or all-zero in every cycle; req_i bits of non-granted requesters SHALL be ignored.

Reset
REQ-028 With rst_n_in low at a rising edge the block SHALL enter IDLE and set gnt_o=0, wr_en=0, wr_addr=0, wr_data=0, clr_busy=0, clr_done=0, round-robin pointer=0, burst count=0 and clear-pending=0.
REQ-029 Reset asserted mid-burst or mid-clear SHALL abort the operation with no further writes; an aborted clear SHALL NOT be resumed.

Verification
REQ-030 Requesters 0 and 2 both request from reset -> gnt_o=3'b001 first; after req0's last beat gnt_o=0 for one cycle, then 3'b100.
REQ-031 Requester 1 has a 3-beat burst to addresses 0x10..0x12, data 0xA1..0xA3, last on beat 3 -> three consecutive wr_en cycles, each one cycle after acceptance, with matching addr/data; gnt_o[1] drops after beat 3.
REQ-032 Requester 0 holds req high with last_i=0 -> exactly 64 writes, forced release, then requester 1 (requesting) is granted next.
REQ-033 clr_req pulsed during requester 2's burst -> burst completes, CLEAR runs 512 writes of 0x00 at addresses 0..511, clr_done pulses once, then pending requester is granted.
REQ-034 hold_in high with req_i=3'b111 -> no grant; hold_in low -> grant on the next edge to pointer index.
REQ-035 rst_n_in low at clear address 200 -> next cycle wr_en=0, clr_busy=0, state IDLE, no clear resumption after release.
